// File: rtl/geofence_feeder.sv
// geofence_feeder: buffers streamed points into PTS-point frames and replays
// each whole frame to geofence back-to-back, returning one tagged result.
// Ports: clk, reset (sync, active-low); in_valid/in_ready/in_x/in_y point
// stream; gf_reset/gf_x/gf_y drive geofence, gf_valid/gf_is_inside return
// its verdict; res_valid/res_inside/res_timeout/res_id result; busy.
module geofence_feeder #(
   parameter int COORD_W = 10,
   parameter int PTS     = 7,
   parameter int FRAMES  = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   output logic               gf_reset,
   output logic [COORD_W-1:0] gf_x,
   output logic [COORD_W-1:0] gf_y,
   input  logic               gf_valid,
   input  logic               gf_is_inside,
   output logic               res_valid,
   output logic               res_inside,
   output logic               res_timeout,
   output logic [7:0]         res_id,
   output logic               busy
);

   localparam int DEPTH = FRAMES * PTS;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (PTS > 1) ? $clog2(PTS) : 1;
   localparam int FW = $clog2(FRAMES + 1);
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_RECOVER
   } state_t;

   state_t state, state_n;

   logic [2*COORD_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [IW-1:0] pt_cnt;
   logic [IW-1:0] idx, idx_n;
   logic [FW-1:0] frames_avail;
   logic [WW-1:0] wait_cnt, wait_n;
   logic          rec_cnt, rec_n;
   logic          gf_rst_q, gf_rst_n;
   logic          rdy_en;
   logic [7:0]    frame_id;

   logic push;
   logic pop;
   logic first;
   logic frame_done;
   logic fire;
   logic fire_to;

   // rdy_en keeps the stream closed on the first edge after reset release
   assign in_ready   = reset & rdy_en & (count != CW'(DEPTH));
   assign gf_reset   = gf_rst_q | ~reset;
   assign busy       = (state != S_IDLE);
   assign push       = in_valid & in_ready;
   assign frame_done = push & (pt_cnt == IW'(PTS - 1));
   // only the pop of a frame's first point retires an available frame
   assign first      = pop & (state != S_SEND);

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      wait_n   = wait_cnt;
      rec_n    = rec_cnt;
      gf_rst_n = gf_rst_q;
      pop      = 1'b0;
      fire     = 1'b0;
      fire_to  = 1'b0;
      unique case (state)
         S_IDLE: begin
            gf_rst_n = 1'b0;
            if ((frames_avail != '0) && !gf_rst_q) begin
               pop     = 1'b1;
               idx_n   = IW'(1);
               state_n = S_SEND;
            end
         end
         S_SEND: begin
            pop = 1'b1;
            if (idx == IW'(PTS - 1)) begin
               wait_n  = '0;
               state_n = S_WAIT;
            end else begin
               idx_n = idx + 1'b1;
            end
         end
         S_WAIT: begin
            wait_n = wait_cnt + 1'b1;
            if (gf_valid) begin
               fire = 1'b1;
               // chain the next frame so geofence sees no bubble
               if (frames_avail != '0) begin
                  pop     = 1'b1;
                  idx_n   = IW'(1);
                  state_n = S_SEND;
               end else begin
                  state_n = S_IDLE;
               end
            end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
               fire     = 1'b1;
               fire_to  = 1'b1;
               gf_rst_n = 1'b1;
               rec_n    = 1'b0;
               state_n  = S_RECOVER;
            end
         end
         S_RECOVER: begin
            gf_rst_n = 1'b1;
            rec_n    = 1'b1;
            if (rec_cnt) begin
               gf_rst_n = 1'b0;
               state_n  = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         pt_cnt       <= '0;
         idx          <= '0;
         frames_avail <= '0;
         wait_cnt     <= '0;
         rec_cnt      <= 1'b0;
         gf_rst_q     <= 1'b1;
         rdy_en       <= 1'b0;
         gf_x         <= '0;
         gf_y         <= '0;
         res_valid    <= 1'b0;
         res_inside   <= 1'b0;
         res_timeout  <= 1'b0;
         res_id       <= '0;
         frame_id     <= '0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         wait_cnt <= wait_n;
         rec_cnt  <= rec_n;
         gf_rst_q <= gf_rst_n;
         rdy_en   <= 1'b1;
         count    <= count + CW'(push) - CW'(pop);
         frames_avail <= frames_avail + FW'(frame_done) - FW'(first);
         if (push) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            pt_cnt <= (pt_cnt == IW'(PTS - 1)) ? '0 : pt_cnt + 1'b1;
         end
         if (pop) begin
            {gf_x, gf_y} <= mem[rd_ptr];
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         res_valid <= fire;
         if (fire) begin
            res_inside  <= gf_is_inside & ~fire_to;
            res_timeout <= fire_to;
            res_id      <= frame_id;
            frame_id    <= frame_id + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_x, in_y};
      end
   end

endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder: randomized bench with a queue-based reference model
// and a geofence responder; every cycle the DUT is compared to the model.
module tb_geofence_feeder;

   localparam int CW    = 10;
   localparam int PTS   = 7;
   localparam int FR    = 2;
   localparam int TO    = 64;
   localparam int DEPTH = FR * PTS;
   localparam int IDLE  = 0;
   localparam int SEND  = 1;
   localparam int WAIT  = 2;
   localparam int REC   = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_x = '0;
   logic [CW-1:0] in_y = '0;
   logic          gf_reset;
   logic [CW-1:0] gf_x;
   logic [CW-1:0] gf_y;
   logic          gf_valid = 1'b0;
   logic          gf_is_inside = 1'b0;
   logic          res_valid;
   logic          res_inside;
   logic          res_timeout;
   logic [7:0]    res_id;
   logic          busy;

   always #5 clk = ~clk;

   geofence_feeder #(
      .COORD_W(CW),
      .PTS(PTS),
      .FRAMES(FR),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_x(in_x),
      .in_y(in_y),
      .gf_reset(gf_reset),
      .gf_x(gf_x),
      .gf_y(gf_y),
      .gf_valid(gf_valid),
      .gf_is_inside(gf_is_inside),
      .res_valid(res_valid),
      .res_inside(res_inside),
      .res_timeout(res_timeout),
      .res_id(res_id),
      .busy(busy)
   );

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } pt_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_total = 0;
   int res_seen = 0;

   // reference model
   pt_t        q[$];
   int         pushed_f = 0;
   int         launched_f = 0;
   int         pcount = 0;
   int         phase = IDLE;
   int         sent = 0;
   int         waited = 0;
   int         rec = 0;
   int         lat = 0;
   bit         cur_inside = 1'b0;
   logic       m_rdy = 1'b0;
   logic       m_gfrst = 1'b1;
   logic [CW-1:0] m_gx = '0;
   logic [CW-1:0] m_gy = '0;
   logic       m_rv = 1'b0;
   logic       m_ri = 1'b0;
   logic       m_rt = 1'b0;
   logic [7:0] m_rid = '0;
   logic [7:0] m_fid = '0;

   // responder knobs
   int lat_lo = 3;
   int lat_hi = 3;
   bit never = 1'b0;
   bit spur = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // the geofence stand-in: inside when coordinate sum divisible by 3
   function automatic void launch();
      pt_t p;
      int  s;
      s = 0;
      for (int i = 0; i < PTS; i++) s += int'(q[i].x) + int'(q[i].y);
      cur_inside = ((s % 3) == 0);
      p = q.pop_front();
      m_gx = p.x;
      m_gy = p.y;
      launched_f++;
      sent = 1;
      phase = SEND;
   endfunction

   function automatic void post(input logic ins, input logic to);
      m_rv  = 1'b1;
      m_ri  = ins;
      m_rt  = to;
      m_rid = m_fid;
      m_fid = m_fid + 8'd1;
   endfunction

   always @(posedge clk) begin : mdl
      pt_t p;
      int  avail;
      bit  acc;
      cyc++;
      if (!reset) begin
         q.delete();
         pushed_f = 0;
         launched_f = 0;
         pcount = 0;
         phase = IDLE;
         m_rdy = 1'b0;
         m_gfrst = 1'b1;
         m_gx = '0;
         m_gy = '0;
         m_rv = 1'b0;
         m_ri = 1'b0;
         m_rt = 1'b0;
         m_rid = '0;
         m_fid = '0;
      end else begin
         acc = in_valid && m_rdy && (q.size() < DEPTH);
         avail = pushed_f - launched_f;
         m_rv = 1'b0;
         case (phase)
            IDLE: begin
               if (avail > 0 && !m_gfrst) launch();
               m_gfrst = 1'b0;
            end
            SEND: begin
               p = q.pop_front();
               m_gx = p.x;
               m_gy = p.y;
               sent++;
               if (sent == PTS) begin
                  phase = WAIT;
                  waited = 0;
                  lat = never ? 0 : int'($urandom_range(lat_lo, lat_hi));
               end
            end
            WAIT: begin
               if (gf_valid) begin
                  post(gf_is_inside, 1'b0);
                  if (avail > 0) launch();
                  else phase = IDLE;
               end else if (waited == TO - 1) begin
                  post(1'b0, 1'b1);
                  m_gfrst = 1'b1;
                  phase = REC;
                  rec = 0;
               end else begin
                  waited++;
               end
            end
            default: begin
               rec++;
               if (rec == 2) begin
                  m_gfrst = 1'b0;
                  phase = IDLE;
               end
            end
         endcase
         if (acc) begin
            p.x = in_x;
            p.y = in_y;
            q.push_back(p);
            acc_total++;
            pcount++;
            if (pcount == PTS) begin
               pcount = 0;
               pushed_f++;
            end
         end
         m_rdy = 1'b1;
      end
      #1;
      chk("in_ready", in_ready, m_rdy && (q.size() < DEPTH) && reset);
      chk("gf_reset", gf_reset, m_gfrst || !reset);
      chk("gf_x", gf_x, m_gx);
      chk("gf_y", gf_y, m_gy);
      chk("busy", busy, phase != IDLE);
      chk("res_valid", res_valid, m_rv);
      chk("res_inside", res_inside, m_ri);
      chk("res_timeout", res_timeout, m_rt);
      chk("res_id", res_id, m_rid);
      if (res_valid === 1'b1) res_seen++;
      if (phase == WAIT) begin
         gf_valid = (lat > 0) && (waited + 1 == lat);
         gf_is_inside = cur_inside;
      end else begin
         gf_valid = spur && ($urandom_range(0, 7) == 0);
         gf_is_inside = 1'($urandom_range(0, 1));
      end
   end

   task automatic push(input int x, input int y);
      int n0;
      int k;
      n0 = acc_total;
      k = 0;
      in_valid = 1'b1;
      in_x = CW'(x);
      in_y = CW'(y);
      while (acc_total == n0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (acc_total == n0) chk("push_accept", acc_total - n0, 1);
      in_valid = 1'b0;
   endtask

   task automatic push_rand();
      push(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
   endtask

   task automatic wait_res(input string nm);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (res_valid !== 1'b1 && k < 3000);
      chk({nm, "_seen"}, res_valid, 1);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (!(phase == IDLE && q.size() == 0) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk("idle_busy", busy, 0);
   endtask

   task automatic wait_busy(input string nm);
      int k;
      k = 0;
      while (busy !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk(nm, busy, 1);
   endtask

   int t1x[PTS] = '{5, 1, 9, 12, 9, 1, 0};
   int t1y[PTS] = '{5, 1, 1, 5, 9, 9, 5};
   int bx[21];
   int by[21];
   int t0;
   int base;
   logic [7:0] id_a;
   logic [CW-1:0] gx0;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_gf_reset", gf_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res", {res_valid, res_id}, 0);
      reset = 1'b1;

      // first frame, literal replay and result
      for (int i = 0; i < PTS; i++) push(t1x[i], t1y[i]);
      for (int i = 0; i < PTS; i++) begin
         @(negedge clk);
         chk("t1_gf_x", gf_x, t1x[i]);
         chk("t1_gf_y", gf_y, t1y[i]);
      end
      wait_res("t1");
      chk("t1_res", {res_inside, res_timeout, res_id}, {1'b1, 1'b0, 8'd0});
      wait_idle();

      // fill FIFO behind a slow frame, then chained launch
      lat_lo = 40;
      lat_hi = 40;
      for (int i = 0; i < 21; i++) begin
         bx[i] = int'($urandom_range(0, 1023));
         by[i] = int'($urandom_range(0, 1023));
      end
      for (int i = 0; i < 21; i++) push(bx[i], by[i]);
      chk("t2_full", in_ready, 0);
      wait_res("t2a");
      id_a = res_id;
      chk("t2_chain_x", gf_x, bx[7]);
      chk("t2_chain_y", gf_y, by[7]);
      chk("t2_chain_busy", busy, 1);
      wait_res("t2b");
      chk("t2_id_b", res_id, 32'(id_a + 8'd1));
      wait_res("t2c");
      chk("t2_id_c", res_id, 32'(id_a + 8'd2));
      wait_idle();

      // partial frame never launches
      lat_lo = 2;
      lat_hi = 2;
      gx0 = gf_x;
      for (int i = 0; i < 4; i++) push_rand();
      repeat (10) @(negedge clk);
      chk("t3_partial_busy", busy, 0);
      chk("t3_partial_gx", gf_x, gx0);
      for (int i = 0; i < 3; i++) push_rand();
      wait_busy("t3_launch");
      wait_res("t3");
      wait_idle();

      // timeout and recovery with a queued frame
      never = 1'b1;
      for (int i = 0; i < PTS; i++) push_rand();
      wait_busy("t4_launch");
      t0 = cyc;
      for (int i = 0; i < PTS; i++) push_rand();
      wait_res("t4");
      chk("t4_latency", cyc - t0, PTS - 1 + TO);
      chk("t4_flags", {res_inside, res_timeout}, 2'b01);
      id_a = res_id;
      never = 1'b0;
      chk("t4_gfrst0", gf_reset, 1);
      @(negedge clk);
      chk("t4_gfrst1", gf_reset, 1);
      @(negedge clk);
      chk("t4_gfrst2", gf_reset, 0);
      wait_res("t4q");
      chk("t4q_to", res_timeout, 0);
      chk("t4q_id", res_id, 32'(id_a + 8'd1));
      wait_idle();

      // reset in the middle of SEND
      for (int i = 0; i < PTS; i++) push_rand();
      wait_busy("t5_launch");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("t5_gfrst", gf_reset, 1);
      chk("t5_ready", in_ready, 0);
      chk("t5_rv", res_valid, 0);
      chk("t5_busy", busy, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < PTS; i++) push_rand();
      wait_res("t5");
      chk("t5_id", res_id, 0);
      wait_idle();

      // 257 immediate frames, id wrap, stray gf_valid pulses
      spur = 1'b1;
      lat_lo = 1;
      lat_hi = 1;
      base = res_seen;
      for (int f = 0; f < 257; f++) begin
         for (int i = 0; i < PTS; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_rand();
         end
      end
      wait_idle();
      chk("t6_count", res_seen - base, 257);
      chk("t6_last_id", res_id, 1);

      // random latencies, some beyond the timeout
      lat_lo = 1;
      lat_hi = 80;
      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < PTS; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_rand();
         end
      end
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
